// File: rtl/mips_extended_core.sv
// mips_extended_core: single-cycle 32-bit MIPS core (Harvard, external memories).
// Every instruction completes in one clk cycle. There are no handshakes: each
// cycle the core presents pc, consumes instr and readdata combinationally, and
// commits pc and the register write on the next rising edge.
// Ports:
//   clk       - single clock, all state updates on the rising edge
//   reset_n   - synchronous active-low reset (pc <= RESET_PC, registers <= 0)
//   pc        - current instruction byte address
//   instr     - instruction at pc (combinational from instruction memory)
//   memwrite  - data-memory write strobe, high only for sw (forced low in reset)
//   dataadr   - data address, equal to the ALU result
//   writedata - store data (register rt)
//   readdata  - load data for dataadr (combinational from data memory)
// Configuration macro: MIPS_EXT_IMM_LOGIC_EN adds andi (0x0C) and ori (0x0D);
// without it those opcodes execute as NOPs.

package mips_ext_pkg;
    typedef enum logic [2:0] {
        ALU_ZERO = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_SLT  = 3'd5
    } alu_op_t;
endpackage

// Register file: two combinational read ports, one write port. $0 reads 0.
module mips_regfile (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        we,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] rf [0:31];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (we && (wa != 5'd0)) begin
            rf[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'd0 : rf[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'd0 : rf[ra2];
endmodule

// Datapath: pc register, register file, ALU and next-pc selection.
module mips_datapath import mips_ext_pkg::*; #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [25:0] fields,     // instr[25:0]
    input  logic [31:0] readdata,
    input  logic        regwrite,
    input  logic        regdst,
    input  logic        alusrc,
    input  logic        zeroext,
    input  logic        memtoreg,
    input  logic        branch_eq,
    input  logic        branch_ne,
    input  logic        jump,
    input  logic        jal,
    input  logic        jr,
    input  alu_op_t     alu_op,
    output logic [31:0] pc,
    output logic [31:0] aluout,
    output logic [31:0] writedata
);
    logic [4:0]  rs, rt, rd, wa;
    logic [15:0] imm;
    logic [31:0] immext, srca, srcb, wd, pc4, pcbranch, pc_next;
    logic        zero, taken;

    assign rs  = fields[25:21];
    assign rt  = fields[20:16];
    assign rd  = fields[15:11];
    assign imm = fields[15:0];

    assign immext = zeroext ? {16'd0, imm} : {{16{imm[15]}}, imm};

    mips_regfile rf (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (regwrite),
        .ra1     (rs),
        .ra2     (rt),
        .wa      (wa),
        .wd      (wd),
        .rd1     (srca),
        .rd2     (writedata)
    );

    assign srcb = alusrc ? immext : writedata;

    always_comb begin
        aluout = 32'd0;
        case (alu_op)
            ALU_ADD: aluout = srca + srcb;
            ALU_SUB: aluout = srca - srcb;
            ALU_AND: aluout = srca & srcb;
            ALU_OR:  aluout = srca | srcb;
            ALU_SLT: aluout = {31'd0, $signed(srca) < $signed(srcb)};
            default: aluout = 32'd0;
        endcase
    end

    assign zero  = (aluout == 32'd0);
    assign taken = (branch_eq & zero) | (branch_ne & ~zero);

    // jal links with pc+4 of the current (pre-update) pc.
    assign pc4      = pc + 32'd4;
    assign pcbranch = pc4 + {immext[29:0], 2'b00};
    assign wa       = jal ? 5'd31 : (regdst ? rd : rt);
    assign wd       = jal ? pc4 : (memtoreg ? readdata : aluout);

    // jr takes rs verbatim, including a misaligned target.
    always_comb begin
        pc_next = pc4;
        if (jr)         pc_next = srca;
        else if (jump)  pc_next = {pc4[31:28], fields, 2'b00};
        else if (taken) pc_next = pcbranch;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) pc <= RESET_PC;
        else          pc <= pc_next;
    end
endmodule

module mips_extended_core import mips_ext_pkg::*; #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] pc,
    input  logic [31:0] instr,
    output logic        memwrite,
    output logic [31:0] dataadr,
    output logic [31:0] writedata,
    input  logic [31:0] readdata
);
    logic    regwrite, regdst, alusrc, zeroext, memtoreg;
    logic    branch_eq, branch_ne, jump, jal, jr, mw;
    alu_op_t alu_op;
    logic [5:0] op, funct;

    assign op    = instr[31:26];
    assign funct = instr[5:0];

    // Decode. Anything not listed leaves the defaults: a NOP with aluout = 0.
    always_comb begin
        regwrite  = 1'b0;
        regdst    = 1'b0;
        alusrc    = 1'b0;
        zeroext   = 1'b0;
        memtoreg  = 1'b0;
        branch_eq = 1'b0;
        branch_ne = 1'b0;
        jump      = 1'b0;
        jal       = 1'b0;
        jr        = 1'b0;
        mw        = 1'b0;
        alu_op    = ALU_ZERO;
        case (op)
            6'h00: begin
                case (funct)
                    6'h20: begin regwrite = 1'b1; regdst = 1'b1; alu_op = ALU_ADD; end
                    6'h22: begin regwrite = 1'b1; regdst = 1'b1; alu_op = ALU_SUB; end
                    6'h24: begin regwrite = 1'b1; regdst = 1'b1; alu_op = ALU_AND; end
                    6'h25: begin regwrite = 1'b1; regdst = 1'b1; alu_op = ALU_OR;  end
                    6'h2A: begin regwrite = 1'b1; regdst = 1'b1; alu_op = ALU_SLT; end
                    6'h08: jr = 1'b1;
                    default: ;
                endcase
            end
            6'h08: begin regwrite = 1'b1; alusrc = 1'b1; alu_op = ALU_ADD; end
            6'h23: begin regwrite = 1'b1; alusrc = 1'b1; memtoreg = 1'b1; alu_op = ALU_ADD; end
            6'h2B: begin mw = 1'b1; alusrc = 1'b1; alu_op = ALU_ADD; end
            6'h04: begin branch_eq = 1'b1; alu_op = ALU_SUB; end
            6'h05: begin branch_ne = 1'b1; alu_op = ALU_SUB; end
            6'h02: jump = 1'b1;
            6'h03: begin jump = 1'b1; jal = 1'b1; regwrite = 1'b1; end
`ifdef MIPS_EXT_IMM_LOGIC_EN
            6'h0C: begin regwrite = 1'b1; alusrc = 1'b1; zeroext = 1'b1; alu_op = ALU_AND; end
            6'h0D: begin regwrite = 1'b1; alusrc = 1'b1; zeroext = 1'b1; alu_op = ALU_OR;  end
`else
            6'h0C, 6'h0D: ;
`endif
            default: ;
        endcase
    end

    assign memwrite = mw & reset_n;

    mips_datapath #(.RESET_PC(RESET_PC)) dp (
        .clk       (clk),
        .reset_n   (reset_n),
        .fields    (instr[25:0]),
        .readdata  (readdata),
        .regwrite  (regwrite),
        .regdst    (regdst),
        .alusrc    (alusrc),
        .zeroext   (zeroext),
        .memtoreg  (memtoreg),
        .branch_eq (branch_eq),
        .branch_ne (branch_ne),
        .jump      (jump),
        .jal       (jal),
        .jr        (jr),
        .alu_op    (alu_op),
        .pc        (pc),
        .aluout    (dataadr),
        .writedata (writedata)
    );
endmodule

// File: tb/tb_mips_extended_core.sv
// Testbench for mips_extended_core. The driver applies one instruction per
// cycle (at posedge+2) and queues the expected outputs: combinational ones are
// checked by the monitor at the following negedge, committed state (pc and
// registers) one time unit after the executing rising edge.
module tb_mips_extended_core;
    logic        clk;
    logic        reset_n;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;

    localparam int K_PC  = 0;
    localparam int K_ADR = 1;
    localparam int K_MW  = 2;
    localparam int K_WD  = 3;
    localparam int K_REG = 4;

    typedef struct {
        string       name;
        int          kind;
        logic [4:0]  sel;
        logic [31:0] exp;
    } chk_t;

    chk_t now_q[$];
    chk_t after_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    mips_extended_core dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pc        (pc),
        .instr     (instr),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .readdata  (readdata)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic apply(input logic rst, input logic [31:0] ins, input logic [31:0] rdv);
        reset_n  = rst;
        instr    = ins;
        readdata = rdv;
    endtask

    task automatic exp_now(input string nm, input int k, input logic [4:0] s, input logic [31:0] v);
        chk_t c;
        c.name = nm; c.kind = k; c.sel = s; c.exp = v;
        now_q.push_back(c);
    endtask

    task automatic exp_after(input string nm, input int k, input logic [4:0] s, input logic [31:0] v);
        chk_t c;
        c.name = nm; c.kind = k; c.sel = s; c.exp = v;
        after_q.push_back(c);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // scoreboard compare
    task automatic check(input chk_t c);
        logic [31:0] act;
        case (c.kind)
            K_PC:    act = pc;
            K_ADR:   act = dataadr;
            K_MW:    act = {31'd0, memwrite};
            K_WD:    act = writedata;
            K_REG:   act = dut.dp.rf.rf[c.sel];
            default: act = 'x;
        endcase
        n_cmp++;
        if (act !== c.exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
        end
    endtask

    // monitor
    initial begin
        forever begin
            @(negedge clk);
            while (now_q.size() > 0) check(now_q.pop_front());
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            while (after_q.size() > 0) check(after_q.pop_front());
        end
    end

    // stimulus
    initial begin
        reset_n  = 1'b0;
        instr    = 32'd0;
        readdata = 32'd0;
        tick();

        // reset with a store presented: strobe must stay low
        apply(1'b0, 32'hAC030008, 32'd0);
        exp_now("rst_memwrite", K_MW, 5'd0, 32'd0);
        exp_after("rst_pc", K_PC, 5'd0, 32'h0);
        exp_after("rst_r3", K_REG, 5'd3, 32'h0);
        exp_after("rst_r31", K_REG, 5'd31, 32'h0);
        tick();

        // add $3,$1,$2
        apply(1'b1, 32'h00221820, 32'd0);
        exp_now("add_pc", K_PC, 5'd0, 32'h0);
        exp_now("add_alu", K_ADR, 5'd0, 32'h0);
        exp_after("add_r3", K_REG, 5'd3, 32'h0);
        exp_after("add_pc_next", K_PC, 5'd0, 32'h4);
        tick();

        // addi $3,$1,1
        apply(1'b1, 32'h20230001, 32'd0);
        exp_now("addi_alu", K_ADR, 5'd0, 32'h1);
        exp_after("addi_r3", K_REG, 5'd3, 32'h1);
        tick();

        // sub $3,$1,$3 -> 0 - 1
        apply(1'b1, 32'h00231822, 32'd0);
        exp_now("sub_alu", K_ADR, 5'd0, 32'hFFFFFFFF);
        exp_after("sub_r3", K_REG, 5'd3, 32'hFFFFFFFF);
        tick();

        // slt $4,$3,$0 -> signed -1 < 0
        apply(1'b1, 32'h0060202A, 32'd0);
        exp_now("slt_alu", K_ADR, 5'd0, 32'h1);
        exp_after("slt_r4", K_REG, 5'd4, 32'h1);
        exp_after("slt_pc", K_PC, 5'd0, 32'h10);
        tick();

        // beq $1,$1,1 at 0x10
        apply(1'b1, 32'h10210001, 32'd0);
        exp_now("beq_memwrite", K_MW, 5'd0, 32'd0);
        exp_after("beq_pc", K_PC, 5'd0, 32'h18);
        tick();

        // bne $1,$1,1 at 0x18 (not taken)
        apply(1'b1, 32'h14210001, 32'd0);
        exp_after("bne_nt_pc", K_PC, 5'd0, 32'h1C);
        tick();

        // j 16 at 0x1C
        apply(1'b1, 32'h08000010, 32'd0);
        exp_after("j_pc", K_PC, 5'd0, 32'h40);
        tick();

        // jal 20 at 0x40
        apply(1'b1, 32'h0C000014, 32'd0);
        exp_after("jal_pc", K_PC, 5'd0, 32'h50);
        exp_after("jal_r31", K_REG, 5'd31, 32'h44);
        tick();

        // addi $3,$0,1
        apply(1'b1, 32'h20030001, 32'd0);
        exp_after("addi2_r3", K_REG, 5'd3, 32'h1);
        tick();

        // bne $3,$0,1 at 0x54 (taken)
        apply(1'b1, 32'h14600001, 32'd0);
        exp_now("bne_t_alu", K_ADR, 5'd0, 32'h1);
        exp_after("bne_t_pc", K_PC, 5'd0, 32'h5C);
        tick();

        // addi $4,$0,0x30 (jr source)
        apply(1'b1, 32'h20040030, 32'd0);
        exp_after("addi3_r4", K_REG, 5'd4, 32'h30);
        tick();

        // jr $4 at 0x60
        apply(1'b1, 32'h00800008, 32'd0);
        exp_now("jr_memwrite", K_MW, 5'd0, 32'd0);
        exp_after("jr_pc", K_PC, 5'd0, 32'h30);
        exp_after("jr_r4", K_REG, 5'd4, 32'h30);
        exp_after("jr_r31", K_REG, 5'd31, 32'h44);
        exp_after("jr_r3", K_REG, 5'd3, 32'h1);
        tick();

        // sw $3,8($0)
        apply(1'b1, 32'hAC030008, 32'd0);
        exp_now("sw_memwrite", K_MW, 5'd0, 32'd1);
        exp_now("sw_adr", K_ADR, 5'd0, 32'h8);
        exp_now("sw_wdata", K_WD, 5'd0, 32'h1);
        exp_after("sw_pc", K_PC, 5'd0, 32'h34);
        tick();

        // lw $5,8($0)
        apply(1'b1, 32'h8C050008, 32'hDEADBEEF);
        exp_now("lw_memwrite", K_MW, 5'd0, 32'd0);
        exp_now("lw_adr", K_ADR, 5'd0, 32'h8);
        exp_after("lw_r5", K_REG, 5'd5, 32'hDEADBEEF);
        tick();

        // addi $0,$3,5: write to $0 discarded
        apply(1'b1, 32'h20600005, 32'd0);
        exp_now("r0_alu", K_ADR, 5'd0, 32'h6);
        exp_after("r0_keep", K_REG, 5'd0, 32'h0);
        tick();

        // andi $6,$5,0x00FF
        apply(1'b1, 32'h30A600FF, 32'd0);
`ifdef MIPS_EXT_IMM_LOGIC_EN
        exp_now("andi_alu", K_ADR, 5'd0, 32'hEF);
        exp_after("andi_r6", K_REG, 5'd6, 32'hEF);
`else
        exp_now("andi_nop_alu", K_ADR, 5'd0, 32'h0);
        exp_after("andi_nop_r6", K_REG, 5'd6, 32'h0);
`endif
        exp_after("andi_pc", K_PC, 5'd0, 32'h40);
        tick();

        // and $7,$5,$4
        apply(1'b1, 32'h00A43824, 32'd0);
        exp_after("and_r7", K_REG, 5'd7, 32'h20);
        tick();

        // or $8,$5,$4
        apply(1'b1, 32'h00A44025, 32'd0);
        exp_after("or_r8", K_REG, 5'd8, 32'hDEADBEFF);
        tick();

        // add $9,$5,$5 wraps
        apply(1'b1, 32'h00A54820, 32'd0);
        exp_after("add_wrap_r9", K_REG, 5'd9, 32'hBD5B7DDE);
        exp_after("add_wrap_pc", K_PC, 5'd0, 32'h4C);
        tick();

        // beq $0,$0,-3 at 0x4C (backward)
        apply(1'b1, 32'h1000FFFD, 32'd0);
        exp_after("beq_back_pc", K_PC, 5'd0, 32'h44);
        tick();

        // unsupported funct 0 with rd=10: NOP
        apply(1'b1, 32'h00A55000, 32'd0);
        exp_now("nop_alu", K_ADR, 5'd0, 32'h0);
        exp_now("nop_memwrite", K_MW, 5'd0, 32'd0);
        exp_after("nop_r10", K_REG, 5'd10, 32'h0);
        exp_after("nop_pc", K_PC, 5'd0, 32'h48);
        tick();

        // reset asserted during sw
        apply(1'b0, 32'hAC030008, 32'd0);
        exp_now("rst_sw_memwrite", K_MW, 5'd0, 32'd0);
        exp_after("rst_sw_pc", K_PC, 5'd0, 32'h0);
        exp_after("rst_sw_r5", K_REG, 5'd5, 32'h0);
        tick();

        // first instruction after reset
        apply(1'b1, 32'h20030001, 32'd0);
        exp_after("post_rst_pc", K_PC, 5'd0, 32'h4);
        exp_after("post_rst_r3", K_REG, 5'd3, 32'h1);
        tick();

        apply(1'b1, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #3;
        if (now_q.size() != 0 || after_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", now_q.size() + after_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
